// File: rtl/root_req_dispatch.sv
// root_req_dispatch: request FIFO and single-in-flight launcher for the
// fixed-point root engine. Degree-0 requests are answered locally with an
// error response. Optional engine watchdog: define ROOT_REQ_DISPATCH_WATCHDOG_EN.
module root_req_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_radicand,
  input  logic [2:0]  req_degree,
  output logic        eng_in_valid,
  output logic [9:0]  eng_data_1,
  output logic [2:0]  eng_data_2,
  input  logic        eng_out_valid,
  input  logic [19:0] eng_out_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [19:0] rsp_data,
  output logic [9:0]  rsp_radicand,
  output logic [2:0]  rsp_degree,
  output logic        rsp_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  logic [TW-1:0] wd_cnt;
  logic          timed_out;   // current RESP is a timeout response
  logic          eng_ov_q;    // previous-cycle eng_out_valid, for edge detect
  logic          stale_seen;  // late result already arrived before DRAIN
  logic          eng_rise;
  assign eng_rise = eng_out_valid && !eng_ov_q;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  state_t        state;
  logic [12:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [9:0]    head_rad;
  logic [2:0]    head_deg;

  // No look-ahead on a same-cycle pop: a full queue always refuses.
  assign req_ready = (count != FULL);
  assign push      = req_valid && req_ready;
  // Lingering eng_out_valid (second result cycle) must not overlap a new launch.
  assign pop       = (state == IDLE) && (count != '0) && !eng_out_valid;
  assign {head_rad, head_deg} = mem[rd_ptr];

  // Queue storage; contents need no reset since count guards reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_radicand, req_degree};
  end

  // Queue pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Dispatch FSM with registered engine and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      eng_in_valid <= 1'b0;
      eng_data_1   <= '0;
      eng_data_2   <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_radicand <= '0;
      rsp_degree   <= '0;
      rsp_err      <= 1'b0;
`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
      wd_cnt       <= '0;
      timed_out    <= 1'b0;
      eng_ov_q     <= 1'b0;
      stale_seen   <= 1'b0;
`endif
    end else begin
      eng_in_valid <= 1'b0;
`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
      eng_ov_q     <= eng_out_valid;
`endif
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_deg == 3'd0) begin
              rsp_valid    <= 1'b1;
              rsp_data     <= '0;
              rsp_err      <= 1'b1;
              rsp_radicand <= head_rad;
              rsp_degree   <= head_deg;
              state        <= RESP;
            end else begin
              eng_data_1   <= head_rad;
              eng_data_2   <= head_deg;
              eng_in_valid <= 1'b1;
              state        <= WAIT;
`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
              wd_cnt       <= '0;
`endif
            end
          end
        end
        WAIT: begin
          // Echo comes from the launch registers, which still hold the request.
          if (eng_out_valid) begin
            rsp_valid    <= 1'b1;
            rsp_data     <= eng_out_data;
            rsp_err      <= 1'b0;
            rsp_radicand <= eng_data_1;
            rsp_degree   <= eng_data_2;
            state        <= RESP;
          end
`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
          else if (wd_cnt == TMAX) begin
            rsp_valid    <= 1'b1;
            rsp_data     <= 20'hFFFFF;
            rsp_err      <= 1'b1;
            rsp_radicand <= eng_data_1;
            rsp_degree   <= eng_data_2;
            timed_out    <= 1'b1;
            stale_seen   <= 1'b0;
            state        <= RESP;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
          // The late result may land while the host still holds off.
          if (timed_out && eng_rise) stale_seen <= 1'b1;
`endif
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
            state     <= timed_out ? DRAIN : IDLE;
            timed_out <= 1'b0;
`else
            state     <= IDLE;
`endif
          end
        end
`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
        DRAIN: begin
          // Swallow the stale result before the engine is reused.
          if (stale_seen || eng_rise) begin
            stale_seen <= 1'b0;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_root_req_dispatch.sv
// Directed bench for root_req_dispatch: vector table for single requests,
// hand-written sequences for queue-full, hold-off, 2-cycle engine valid,
// watchdog (when compiled in) and mid-operation reset.
module tb_root_req_dispatch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_radicand;
  logic [2:0]  req_degree;
  logic        eng_in_valid;
  logic [9:0]  eng_data_1;
  logic [2:0]  eng_data_2;
  logic        eng_out_valid;
  logic [19:0] eng_out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_data;
  logic [9:0]  rsp_radicand;
  logic [2:0]  rsp_degree;
  logic        rsp_err;

  int n_chk = 0;
  int n_fail = 0;
  int launch_cnt = 0;
  int hs_cnt = 0;

  root_req_dispatch #(.DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_radicand(req_radicand), .req_degree(req_degree),
    .eng_in_valid(eng_in_valid), .eng_data_1(eng_data_1), .eng_data_2(eng_data_2),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_radicand(rsp_radicand), .rsp_degree(rsp_degree), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Count launches and accepted responses between edges.
  always @(negedge clk) begin
    if (rst_n && eng_in_valid) launch_cnt = launch_cnt + 1;
    if (rst_n && rsp_valid && rsp_ready) hs_cnt = hs_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [9:0]  rad;
    logic [2:0]  deg;
    logic [19:0] res;       // value the engine model returns
    logic        launch;    // expect an engine launch
    logic [19:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Push one request; operands are scrambled right after the push cycle.
  task automatic push(input logic [9:0] r, input logic [2:0] d);
    req_valid = 1'b1; req_radicand = r; req_degree = d;
    tick();
    req_valid = 1'b0; req_radicand = 10'h3FF; req_degree = 3'd7;
  endtask

  // Wait for launch number base+1, check operands, return a 2-cycle result, accept it.
  task automatic serve(input string nm, input logic [9:0] rad, input logic [2:0] deg,
                       input logic [19:0] res, input int base);
    for (int k = 0; k < 60 && launch_cnt <= base; k++) tick();
    check({nm, "_launched"}, launch_cnt - base, 1);
    check({nm, "_eng_data_1"}, eng_data_1, rad);
    check({nm, "_eng_data_2"}, eng_data_2, deg);
    repeat (3) begin
      tick();
      check({nm, "_hold_data_1"}, eng_data_1, rad);
      check({nm, "_hold_data_2"}, eng_data_2, deg);
    end
    eng_out_valid = 1'b1; eng_out_data = res;
    tick();
    check({nm, "_rsp_valid"}, rsp_valid, 1);
    tick();
    eng_out_valid = 1'b0; eng_out_data = '0;
    check({nm, "_rsp_data"}, rsp_data, res);
    check({nm, "_rsp_radicand"}, rsp_radicand, rad);
    check({nm, "_rsp_degree"}, rsp_degree, deg);
    check({nm, "_rsp_err"}, rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int b, h;
    vecs[0] = '{10'd16,   3'd2, 20'h01000, 1'b1, 20'h01000, 1'b0};
    vecs[1] = '{10'd27,   3'd3, 20'h00C00, 1'b1, 20'h00C00, 1'b0};
    vecs[2] = '{10'd100,  3'd0, 20'h0ABCD, 1'b0, 20'h00000, 1'b1};
    vecs[3] = '{10'd1023, 3'd1, 20'hFFC00, 1'b1, 20'hFFC00, 1'b0};
    vecs[4] = '{10'd0,    3'd2, 20'h00000, 1'b1, 20'h00000, 1'b0};
    vecs[5] = '{10'd1000, 3'd3, 20'h02800, 1'b1, 20'h02800, 1'b0};
    vecs[6] = '{10'd7,    3'd0, 20'h12345, 1'b0, 20'h00000, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_radicand = '0; req_degree = '0;
    eng_out_valid = 1'b0; eng_out_data = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_eng_in_valid", eng_in_valid, 0);
    check("rst_eng_data_1", eng_data_1, 0);
    check("rst_eng_data_2", eng_data_2, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single-request vectors.
    for (int i = 0; i < 7; i++) begin
      vec_t v;
      v = vecs[i];
      b = launch_cnt;
      push(v.rad, v.deg);
      check($sformatf("v%0d_pre_launch", i), eng_in_valid, 0);
      tick();
      if (v.launch) begin
        check($sformatf("v%0d_eng_in_valid", i), eng_in_valid, 1);
        check($sformatf("v%0d_eng_data_1", i), eng_data_1, v.rad);
        check($sformatf("v%0d_eng_data_2", i), eng_data_2, v.deg);
        tick();
        check($sformatf("v%0d_pulse_len", i), eng_in_valid, 0);
        repeat (2) tick();
        eng_out_valid = 1'b1; eng_out_data = v.res;
        tick();
        check($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
        tick();
        eng_out_valid = 1'b0; eng_out_data = '0;
      end else begin
        check($sformatf("v%0d_no_launch", i), eng_in_valid, 0);
        check($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      end
      check($sformatf("v%0d_rsp_data", i), rsp_data, v.exp_data);
      check($sformatf("v%0d_rsp_err", i), rsp_err, v.exp_err);
      check($sformatf("v%0d_rsp_radicand", i), rsp_radicand, v.rad);
      check($sformatf("v%0d_rsp_degree", i), rsp_degree, v.deg);
      check($sformatf("v%0d_launch_cnt", i), launch_cnt - b, v.launch ? 1 : 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_done", i), rsp_valid, 0);
    end

    // Queue full: eng_out_valid high keeps IDLE from popping.
    eng_out_valid = 1'b1;
    b = launch_cnt;
    for (int i = 0; i < 4; i++) begin
      push(10'(201 + i), 3'(1 + i));
      check($sformatf("fill%0d_req_ready", i), req_ready, (i < 3) ? 1 : 0);
    end
    req_valid = 1'b1; req_radicand = 10'd205; req_degree = 3'd5;
    tick();
    check("fill_held_off", req_ready, 0);
    check("fill_no_launch", launch_cnt - b, 0);
    eng_out_valid = 1'b0;
    for (int k = 0; k < 20 && !req_ready; k++) tick();
    check("fill_ready_again", req_ready, 1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++)
      serve($sformatf("fifo%0d", i), 10'(201 + i), 3'(1 + i), 20'(32'h100 * (i + 1)), b + i);

    // rsp_ready tied high, engine valid for 2 cycles: one response, relaunch after valid drops.
    rsp_ready = 1'b1;
    b = launch_cnt; h = hs_cnt;
    push(10'd400, 3'd2);
    push(10'd401, 3'd1);
    repeat (2) tick();
    eng_out_valid = 1'b1; eng_out_data = 20'h55555;
    tick();
    check("two_cyc_rsp_valid", rsp_valid, 1);
    check("two_cyc_rsp_data", rsp_data, 20'h55555);
    tick();
    check("two_cyc_no_relaunch", launch_cnt - b, 1);
    eng_out_valid = 1'b0; eng_out_data = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("two_cyc_one_rsp", hs_cnt - h, 1);
    check("two_cyc_relaunch", launch_cnt - b, 2);
    serve("two_cyc_next", 10'd401, 3'd1, 20'h00400, b + 1);

    // Host stalls the response for 10 cycles.
    b = launch_cnt;
    push(10'd500, 3'd0);
    push(10'd501, 3'd2);
    for (int k = 0; k < 10; k++) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, 0);
      check("hold_rsp_err", rsp_err, 1);
      check("hold_rsp_radicand", rsp_radicand, 500);
      tick();
    end
    check("hold_no_launch", launch_cnt - b, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    serve("hold_next", 10'd501, 3'd2, 20'h016A1, b);

`ifdef ROOT_REQ_DISPATCH_WATCHDOG_EN
    // Watchdog: silent engine, timeout response, late result dropped.
    b = launch_cnt; h = hs_cnt;
    push(10'd300, 3'd2);
    push(10'd301, 3'd3);
    for (int k = 0; k < 30 && !rsp_valid; k++) tick();
    check("wd_rsp_valid", rsp_valid, 1);
    check("wd_rsp_data", rsp_data, 20'hFFFFF);
    check("wd_rsp_err", rsp_err, 1);
    check("wd_rsp_radicand", rsp_radicand, 300);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (5) tick();
    check("wd_drain_no_launch", launch_cnt - b, 1);
    eng_out_valid = 1'b1; eng_out_data = 20'h12345;
    repeat (2) tick();
    eng_out_valid = 1'b0; eng_out_data = '0;
    check("wd_late_dropped", rsp_valid, 0);
    check("wd_one_rsp", hs_cnt - h, 1);
    serve("wd_next", 10'd301, 3'd3, 20'h00C00, b + 1);
`endif

    // Reset asserted mid-WAIT drops everything at once.
    push(10'd600, 3'd3);
    push(10'd601, 3'd2);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_eng_in_valid", eng_in_valid, 0);
    check("mid_rst_eng_data_1", eng_data_1, 0);
    check("mid_rst_eng_data_2", eng_data_2, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_rsp_radicand", rsp_radicand, 0);
    check("mid_rst_rsp_err", rsp_err, 0);
    @(negedge clk) rst_n = 1'b1;
    b = launch_cnt;
    repeat (4) tick();
    check("post_rst_queue_empty", launch_cnt - b, 0);
    check("post_rst_rsp_valid", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
